// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: width defaults, ALU opcodes and the
// multiplier FSM state encoding.
package ex_stage_pkg;

    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefAluW     = 4;
    localparam int unsigned DefRegAddrW = 5;

    localparam logic [DefAluW-1:0] AluAdd = 4'd0;
    localparam logic [DefAluW-1:0] AluSub = 4'd1;
    localparam logic [DefAluW-1:0] AluAnd = 4'd2;
    localparam logic [DefAluW-1:0] AluOr  = 4'd3;
    localparam logic [DefAluW-1:0] AluXor = 4'd4;
    localparam logic [DefAluW-1:0] AluLui = 4'd5;
    localparam logic [DefAluW-1:0] AluSll = 4'd6;
    localparam logic [DefAluW-1:0] AluSrl = 4'd7;
    localparam logic [DefAluW-1:0] AluSra = 4'd8;
    localparam logic [DefAluW-1:0] AluSlt = 4'd9;
    localparam logic [DefAluW-1:0] AluMul = 4'd10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The slave modport is the execute stage;
// the master modport is the surrounding pipeline.
interface ex_stage_if #(
    parameter int unsigned DATA_W     = ex_stage_pkg::DefDataW,
    parameter int unsigned ALU_W      = ex_stage_pkg::DefAluW,
    parameter int unsigned REG_ADDR_W = ex_stage_pkg::DefRegAddrW
) ();

    logic                  in_valid;
    logic                  write_reg;
    logic                  mem_to_reg;
    logic                  write_mem;
    logic [ALU_W-1:0]      aluc;
    logic                  shift;
    logic                  alu_imm;
    logic [DATA_W-1:0]     operand_1;
    logic [DATA_W-1:0]     operand_2;
    logic [DATA_W-1:0]     operand_imm;
    logic [REG_ADDR_W-1:0] des_r;
    logic                  mem_stall_i;

    logic                  stall_o;
    logic                  busy;
    logic                  out_valid;
    logic                  mem_write_reg;
    logic                  mem_mem_to_reg;
    logic                  mem_write_mem;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] mem_des_r;

    modport slave (
        input  in_valid, write_reg, mem_to_reg, write_mem, aluc, shift, alu_imm,
               operand_1, operand_2, operand_imm, des_r, mem_stall_i,
        output stall_o, busy, out_valid, mem_write_reg, mem_mem_to_reg, mem_write_mem,
               alu_result, store_data, mem_des_r
    );

    modport master (
        output in_valid, write_reg, mem_to_reg, write_mem, aluc, shift, alu_imm,
               operand_1, operand_2, operand_imm, des_r, mem_stall_i,
        input  stall_o, busy, out_valid, mem_write_reg, mem_mem_to_reg, mem_write_mem,
               alu_result, store_data, mem_des_r
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock, DATA_W steps,
// low DATA_W bits of the product held in DONE for one cycle. hold freezes everything.
module ex_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CntW = $clog2(DATA_W);

    mul_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StBusy;
                    end
                end
                StBusy: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU and the EX/MEM register.
// Define EX_MUL_EN to build the iterative multiplier; otherwise MUL yields 0.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned ALU_W      = DefAluW,
    parameter int unsigned REG_ADDR_W = DefRegAddrW
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic                  write_reg;
        logic                  mem_to_reg;
        logic                  write_mem;
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] des_r;
    } ex_mem_t;

    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic              mul_wait;
    ex_mem_t           ex_mem_q, ex_mem_d;

    assign op_a = bus.shift ? {{(DATA_W-5){1'b0}}, bus.operand_imm[10:6]} : bus.operand_1;
    assign op_b = bus.alu_imm ? bus.operand_imm : bus.operand_2;

`ifdef EX_MUL_EN
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    assign is_mul    = bus.in_valid && (bus.aluc == AluMul);
    assign mul_start = is_mul && !mul_busy && !bus.mem_stall_i;
    // Hold the MUL in ID/EX until the product is sitting in DONE.
    assign mul_wait  = is_mul && !mul_done;
    assign bus.busy  = mul_busy;

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .hold    (bus.mem_stall_i),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_wait = 1'b0;
    assign bus.busy = 1'b0;
`endif

    assign bus.stall_o = bus.mem_stall_i | mul_wait;

    always_comb begin
        alu_res = '0;
        case (bus.aluc)
            AluAdd:  alu_res = op_a + op_b;
            AluSub:  alu_res = op_a - op_b;
            AluAnd:  alu_res = op_a & op_b;
            AluOr:   alu_res = op_a | op_b;
            AluXor:  alu_res = op_a ^ op_b;
            AluLui:  alu_res = op_b << 16;
            AluSll:  alu_res = op_b << op_a[4:0];
            AluSrl:  alu_res = op_b >> op_a[4:0];
            AluSra:  alu_res = $signed(op_b) >>> op_a[4:0];
            AluSlt:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef EX_MUL_EN
            AluMul:  alu_res = mul_product;
`endif
            default: alu_res = '0;
        endcase
    end

    // Bubbles and in-flight multiplies load an all-zero entry.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!bus.mem_stall_i) begin
            ex_mem_d = '0;
            if (bus.in_valid && !mul_wait) begin
                ex_mem_d.valid      = 1'b1;
                ex_mem_d.write_reg  = bus.write_reg;
                ex_mem_d.mem_to_reg = bus.mem_to_reg;
                ex_mem_d.write_mem  = bus.write_mem;
                ex_mem_d.result     = alu_res;
                ex_mem_d.store_data = bus.operand_2;
                ex_mem_d.des_r      = bus.des_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign bus.out_valid      = ex_mem_q.valid;
    assign bus.mem_write_reg  = ex_mem_q.write_reg;
    assign bus.mem_mem_to_reg = ex_mem_q.mem_to_reg;
    assign bus.mem_write_mem  = ex_mem_q.write_mem;
    assign bus.alu_result     = ex_mem_q.result;
    assign bus.store_data     = ex_mem_q.store_data;
    assign bus.mem_des_r      = ex_mem_q.des_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; multiply sequences run only when EX_MUL_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic        wr;
        logic        m2r;
        logic        wm;
        logic [3:0]  aluc;
        logic        sh;
        logic        ai;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  des;
        logic [31:0] exp_res;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] outs();
        return {bus.out_valid, bus.mem_write_reg, bus.mem_mem_to_reg, bus.mem_write_mem,
                bus.alu_result, bus.store_data, bus.mem_des_r};
    endfunction

    function automatic logic [72:0] exp_of(input vec_t t);
        if (!t.v) return '0;
        return {1'b1, t.wr, t.m2r, t.wm, t.exp_res, t.op2, t.des};
    endfunction

    task automatic drive(input vec_t t);
        bus.in_valid    = t.v;
        bus.write_reg   = t.wr;
        bus.mem_to_reg  = t.m2r;
        bus.write_mem   = t.wm;
        bus.aluc        = t.aluc;
        bus.shift       = t.sh;
        bus.alu_imm     = t.ai;
        bus.operand_1   = t.op1;
        bus.operand_2   = t.op2;
        bus.operand_imm = t.imm;
        bus.des_r       = t.des;
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] des, input int stall_at, input int stall_len,
                           input int exp_cycles, input logic [31:0] exp_prod);
        int cyc = 0;
        bit bubble_bad = 0;
        bit dropped = 0;
        vec_t m = '{1'b1, 1'b1, 1'b0, 1'b0, AluMul, 1'b0, 1'b0, a, b, 32'h0, des, 32'h0};
        drive(m);
        while (!dropped && cyc < 200) begin
            bus.mem_stall_i = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            #1;
            if (!bus.stall_o) begin
                dropped = 1;
            end else begin
                if (cyc > 0 && bus.out_valid) bubble_bad = 1;
                cyc++;
                @(posedge clk);
                #1;
            end
        end
        check({name, "_stall_cycles"}, cyc, exp_cycles);
        check({name, "_bubbles"}, bubble_bad, 0);
        check({name, "_busy_in_done"}, bus.busy, 1);
        @(posedge clk);
        #1;
        check({name, "_result"}, outs(), {1'b1, 1'b1, 1'b0, 1'b0, exp_prod, b, des});
        check({name, "_busy_idle"}, bus.busy, 0);
    endtask
`endif

    initial begin
        vecs[0]  = '{1, 1, 0, 0, AluAdd, 0, 1, 32'h7FFFFFFF, 32'h00001234, 32'h1, 5'd5, 32'h80000000};
        vecs[1]  = '{1, 1, 0, 0, AluSub, 0, 0, 32'h0, 32'h1, 32'h0, 5'd1, 32'hFFFFFFFF};
        vecs[2]  = '{1, 1, 0, 0, AluAnd, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd2, 32'hF000F000};
        vecs[3]  = '{1, 1, 0, 0, AluOr, 0, 0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 5'd3, 32'hFFFFF0F0};
        vecs[4]  = '{1, 1, 0, 0, AluXor, 0, 0, 32'hAAAAAAAA, 32'hFFFF0000, 32'h0, 5'd4, 32'h5555AAAA};
        vecs[5]  = '{1, 1, 0, 0, AluLui, 0, 1, 32'hDEADBEEF, 32'h0, 32'h00001234, 5'd6, 32'h12340000};
        vecs[6]  = '{1, 1, 0, 0, AluSll, 1, 0, 32'h0, 32'h0000000F, 32'h00000100, 5'd7, 32'h000000F0};
        vecs[7]  = '{1, 1, 0, 0, AluSrl, 1, 0, 32'h0, 32'hF0000000, 32'h00000100, 5'd8, 32'h0F000000};
        vecs[8]  = '{1, 1, 0, 0, AluSra, 1, 0, 32'h0, 32'hF0000000, 32'h00000100, 5'd9, 32'hFF000000};
        vecs[9]  = '{1, 1, 0, 0, AluSlt, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd10, 32'h1};
        vecs[10] = '{1, 1, 0, 0, AluSlt, 0, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd11, 32'h0};
        vecs[11] = '{0, 1, 1, 1, AluAdd, 0, 0, 32'h11111111, 32'h22222222, 32'h0, 5'd12, 32'h0};
        vecs[12] = '{1, 0, 0, 1, 4'd15, 0, 0, 32'h5, 32'hCAFEF00D, 32'h0, 5'd0, 32'h0};
        vecs[13] = '{1, 1, 0, 0, AluSll, 0, 0, 32'h00000023, 32'h1, 32'h0, 5'd13, 32'h8};
        vecs[14] = '{1, 1, 1, 0, AluSrl, 1, 0, 32'h12345678, 32'h80000000, 32'hFFFFF87F, 5'd31,
                     32'h40000000};

        drive('{0, 0, 0, 0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0});
        bus.mem_stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), '0);
        check("reset_busy", bus.busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("stall_vec%0d", i), bus.stall_o, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
        end

        // Memory stall on the single-cycle path: register holds, stall_o raised.
        drive(vecs[2]);
        @(posedge clk);
        #1;
        drive(vecs[4]);
        bus.mem_stall_i = 1'b1;
        #1;
        check("mem_stall_stall_o", bus.stall_o, 1);
        repeat (2) @(posedge clk);
        #1;
        check("mem_stall_frozen", outs(), exp_of(vecs[2]));
        bus.mem_stall_i = 1'b0;
        @(posedge clk);
        #1;
        check("mem_stall_release", outs(), exp_of(vecs[4]));

`ifdef EX_MUL_EN
        run_mul("mul_basic", 32'h00010003, 32'h00000005, 5'd7, 0, 0, 33, 32'h0005000F);
        // Issued back-to-back, with MEM stalling three cycles mid-BUSY.
        run_mul("mul_memstall", 32'hFFFFFFFF, 32'h00000003, 5'd9, 6, 3, 36, 32'hFFFFFFFD);

        drive('{1, 1, 0, 0, AluMul, 0, 0, 32'h00000007, 32'h00000009, 32'h0, 5'd4, 32'h0});
        repeat (11) @(posedge clk);
        #1;
        check("rst_mid_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), '0);
        check("rst_mid_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_mul("mul_after_rst", 32'h12345678, 32'h00000010, 5'd3, 0, 0, 33, 32'h23456780);
`else
        drive('{1, 1, 0, 0, AluMul, 0, 0, 32'h00010003, 32'h00000005, 32'h0, 5'd7, 32'h0});
        #1;
        check("nomul_stall_o", bus.stall_o, 0);
        check("nomul_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        check("nomul_result", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00000005, 5'd7});
`endif

        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_bubble", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage: consumes the decoded instruction held in the ID/EX pipeline register and produces the registered EX/MEM payload.
- Single-cycle ALU ops, plus an optional iterative 32-cycle multiplier.
- Drives stall_o back to ID/EX and the fetch/decode stages while a multiply is in flight or memory stalls.
- The EX/MEM output register doubles as the forwarding source for the next instruction.

Parameters:
DATA_W, 32, operand/result width
ALU_W, 4, aluc width
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
write_reg  in  1  instruction writes register file
mem_to_reg  in  1  writeback from memory
write_mem  in  1  store instruction
aluc  in  ALU_W  ALU operation code
shift  in  1  operand A = operand_imm[10:6] (shamt)
alu_imm  in  1  operand B = operand_imm
operand_1  in  DATA_W  rs value
operand_2  in  DATA_W  rt value, also store data
operand_imm  in  DATA_W  sign/zero-extended immediate
des_r  in  REG_ADDR_W  destination register
mem_stall_i  in  1  MEM stage cannot accept
stall_o  out  1  hold ID/EX and earlier stages
busy  out  1  multiplier FSM not IDLE
out_valid  out  1  EX/MEM entry valid
mem_write_reg  out  1  registered write_reg
mem_mem_to_reg  out  1  registered mem_to_reg
mem_write_mem  out  1  registered write_mem
alu_result  out  DATA_W  result / memory address
store_data  out  DATA_W  registered operand_2
mem_des_r  out  REG_ADDR_W  registered des_r

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0; FSM IDLE; iteration counter 0. Reset mid-multiply aborts it; there is no partial result.
- Operand selection:
  - A = shift ? zero-extended operand_imm[10:6] : operand_1.
  - B = alu_imm ? operand_imm : operand_2.
- ALU ops:
  - ADD, SUB: wrap modulo 2^DATA_W, no overflow trap.
  - AND, OR, XOR.
  - LUI: B << 16.
  - SLL, SRL, SRA: shift B by A[4:0].
  - SLT: signed compare, result 1 or 0.
  - MUL: low DATA_W bits of the product.
  - Undefined codes: result 0.
- Single-cycle path, one-cycle latency:
  - If mem_stall_i = 0 and the instruction is not MUL, the output register loads every clock edge.
  - Loaded payload: in_valid plus controls, result, operand_2, des_r.
  - in_valid = 0 loads a bubble with out_valid = 0; the other fields are don't-care but all are cleared to 0.
- mem_stall_i = 1:
  - Output register, FSM and counter all freeze.
  - stall_o = 1.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_valid && aluc == MUL && !mem_stall_i → latch A and B, counter = 0, go BUSY. The output register loads a bubble.
  - BUSY: one shift-add iteration per edge; counter increments. When counter = 31 the iteration completes → DONE. The output register loads bubbles.
  - DONE: the output register captures the product with the MUL's controls → IDLE.
- stall_o = mem_stall_i | (in_valid & aluc == MUL & state != DONE).
- MUL timing, accepted in cycle T:
  - stall_o high T..T+32.
  - DONE in T+33; stall_o low in T+33.
  - out_valid = 1 in T+34.
  - ID/EX advances at the end of T+33.
- busy = (state != IDLE).
- Back-to-back MULs: the second restarts from IDLE in T+34.

Optional Feature:
EX_MUL_EN
- Defined: iterative multiplier and FSM as above.
- Undefined: no FSM or counter. MUL decodes as undefined: result 0, single-cycle. busy is tied 0 and stall_o = mem_stall_i.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ADD 0, SUB 1, AND 2, OR 3, XOR 4, LUI 5, SLL 6, SRL 7, SRA 8, SLT 9, MUL 10.
  - DATA_W, ALU_W, REG_ADDR_W defaults.
  - FSM state encoding.
- One sub-module, ex_mul_iter: shift-add multiplier with start, done and product ports, instantiated under EX_MUL_EN.

Test Plan:
- ADD with alu_imm = 1, operand_1 = 0x7FFFFFFF, imm = 1 → next cycle alu_result = 0x80000000, out_valid = 1, mem_des_r = des_r.
- SRA with shift = 1, imm[10:6] = 4, operand_2 = 0xF0000000 → alu_result = 0xFF000000; SLT of -1 vs 1 → 1.
- MUL 0x0001_0003 × 0x0000_0005 → stall_o high for 33 cycles, then alu_result = 0x0005000F one cycle after stall_o drops; preceding outputs are bubbles.
- mem_stall_i held for 3 cycles during BUSY → counter and outputs frozen, completion delayed exactly 3 cycles.
- rst_n pulsed low at BUSY iteration 10 → all outputs 0 immediately, busy = 0, re-issued MUL completes correctly.
- Build without EX_MUL_EN, MUL issued → stall_o = 0, result 0 after one cycle.
